// File: rtl/arm_pipelined_hazard_controller.sv
// arm_pipelined_hazard_controller
//   Hazard/sequencing controller for the 5-stage ARM pipeline.
//   Produces operand-forwarding selects, load-use stalls, branch flushes and
//   data-memory wait-state stalls. A small FSM tracks outstanding memory
//   accesses, defers branch flushes that land during a memory stall and flags
//   accesses that never complete.
// Ports:
//   i_CLK, i_RESET              clock, synchronous active-high reset
//   i_RA*_Decode/_Execute       source register numbers
//   i_WA3_*                     destination register numbers per stage
//   i_Reg_Write_*               register write enables (Memory, Writeback)
//   i_Mem_To_Reg_Execute        load in Execute
//   i_Branch_Taken_Execute      taken-branch pulse
//   i_Mem_Req_Memory/i_Mem_Ready data-memory handshake
//   o_Forward_A/B_Execute       00 regfile, 01 Writeback, 10 Memory
//   o_Stall_*, o_Flush_*        pipeline register hold / bubble controls
//   o_Mem_Timeout               sticky hung-memory flag
//   o_Stall_Count               saturating count of stalled cycles
module arm_pipelined_hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [3:0]       i_RA1_Decode,
  input  logic [3:0]       i_RA2_Decode,
  input  logic [3:0]       i_RA1_Execute,
  input  logic [3:0]       i_RA2_Execute,
  input  logic [3:0]       i_WA3_Execute,
  input  logic [3:0]       i_WA3_Memory,
  input  logic [3:0]       i_WA3_Writeback,
  input  logic             i_Reg_Write_Memory,
  input  logic             i_Reg_Write_Writeback,
  input  logic             i_Mem_To_Reg_Execute,
  input  logic             i_Branch_Taken_Execute,
  input  logic             i_Mem_Req_Memory,
  input  logic             i_Mem_Ready,
  output logic [1:0]       o_Forward_A_Execute,
  output logic [1:0]       o_Forward_B_Execute,
  output logic             o_Stall_Fetch,
  output logic             o_Stall_Decode,
  output logic             o_Stall_Execute,
  output logic             o_Stall_Memory,
  output logic             o_Flush_Decode,
  output logic             o_Flush_Execute,
  output logic             o_Flush_Writeback,
  output logic             o_Mem_Timeout,
  output logic [CNT_W-1:0] o_Stall_Count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        timeout_set;
  logic        branch_pending;

  logic        mem_stall;
  logic        ldr_stall;
  logic        flush_req;
  logic        any_stall;

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       rw_mem,
                                         input logic [3:0] wa_mem,
                                         input logic       rw_wb,
                                         input logic [3:0] wa_wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'hF) begin
      if (rw_mem && (wa_mem == ra))
        sel = 2'b10;
      else if (rw_wb && (wa_wb == ra))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    o_Forward_A_Execute = fwd_sel(i_RA1_Execute, i_Reg_Write_Memory, i_WA3_Memory,
                                  i_Reg_Write_Writeback, i_WA3_Writeback);
    o_Forward_B_Execute = fwd_sel(i_RA2_Execute, i_Reg_Write_Memory, i_WA3_Memory,
                                  i_Reg_Write_Writeback, i_WA3_Writeback);
  end

  // In WAIT the access is treated as pending even if the request drops,
  // so the stall follows i_Mem_Ready alone there.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      ST_IDLE:  mem_stall = i_Mem_Req_Memory && !i_Mem_Ready;
      ST_WAIT:  mem_stall = !i_Mem_Ready;
      ST_ERROR: mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    ldr_stall = i_Mem_To_Reg_Execute &&
                ((i_WA3_Execute == i_RA1_Decode) || (i_WA3_Execute == i_RA2_Decode));
    flush_req = i_Branch_Taken_Execute || branch_pending;
  end

  always_comb begin
    o_Stall_Fetch     = 1'b0;
    o_Stall_Decode    = 1'b0;
    o_Stall_Execute   = 1'b0;
    o_Stall_Memory    = 1'b0;
    o_Flush_Decode    = 1'b0;
    o_Flush_Execute   = 1'b0;
    o_Flush_Writeback = 1'b0;
    if (mem_stall) begin
      o_Stall_Fetch     = 1'b1;
      o_Stall_Decode    = 1'b1;
      o_Stall_Execute   = 1'b1;
      o_Stall_Memory    = 1'b1;
      o_Flush_Writeback = 1'b1;
    end else if (flush_req) begin
      o_Flush_Decode  = 1'b1;
      o_Flush_Execute = 1'b1;
    end else if (ldr_stall) begin
      o_Stall_Fetch   = 1'b1;
      o_Stall_Decode  = 1'b1;
      o_Flush_Execute = 1'b1;
    end
    any_stall = o_Stall_Fetch || o_Stall_Decode || o_Stall_Execute || o_Stall_Memory;
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Mem_Req_Memory && !i_Mem_Ready) begin
          state_next    = ST_WAIT;
          wait_cnt_next = 16'd1;
        end
      end
      ST_WAIT: begin
        if (i_Mem_Ready) begin
          state_next    = ST_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next  = ST_ERROR;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 16'd1;
        end
      end
      ST_ERROR: state_next = ST_ERROR;
      default: begin
        state_next    = ST_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state          <= ST_IDLE;
      wait_cnt       <= '0;
      branch_pending <= 1'b0;
      o_Mem_Timeout  <= 1'b0;
      o_Stall_Count  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout_set)
        o_Mem_Timeout <= 1'b1;
      if (i_Branch_Taken_Execute && mem_stall)
        branch_pending <= 1'b1;
      else if (flush_req && !mem_stall)
        branch_pending <= 1'b0;
      if (any_stall && (o_Stall_Count != '1))
        o_Stall_Count <= o_Stall_Count + 1'b1;
    end
  end

endmodule
